// File: rtl/mem_sequencer_pkg.sv
// mem_seq_pkg: shared types for the memory sequencer.
//   - state_e     : sequencer FSM states (VSTROBE/VHOLD only with
//                   MEM_SEQUENCER_VERIFY_EN defined)
//   - BANK_W/BLOCK_W/ROW_W : address field widths
//   - mem_addr_t  : packed {bank, block, row} address
//   - addr_incr() : 16-bit wrapping increment of a mem_addr_t
package mem_seq_pkg;

   localparam int unsigned BANK_W  = 4;
   localparam int unsigned BLOCK_W = 4;
   localparam int unsigned ROW_W   = 8;
   localparam int unsigned ADDR_W  = BANK_W + BLOCK_W + ROW_W;

   typedef struct packed {
      logic [BANK_W-1:0]  bank;
      logic [BLOCK_W-1:0] block;
      logic [ROW_W-1:0]   row;
   } mem_addr_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RDWAIT
`ifdef MEM_SEQUENCER_VERIFY_EN
      ,
      VSTROBE,
      VHOLD
`endif
   } state_e;

   // Row carries into block, block into bank, all-ones wraps to zero.
   function automatic mem_addr_t addr_incr(input mem_addr_t a);
      logic [ADDR_W-1:0] v;
      v = a;
      v = v + ADDR_W'(1);
      return v;
   endfunction

endpackage

// File: rtl/mem_sequencer_addr_counter.sv
// mem_addr_counter: burst address register for mem_sequencer.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (address -> 0)
//   load        : take loadValue as the new address (priority over inc)
//   loadValue   : start address of a burst
//   inc         : advance to the next byte address (16-bit wrap)
//   addr        : current address
module mem_addr_counter
   import mem_seq_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      load,
   input  mem_addr_t loadValue,
   input  logic      inc,
   output mem_addr_t addr
);

   mem_addr_t addr_q;
   mem_addr_t addr_d;

   always_comb begin
      addr_d = addr_q;
      if (load) begin
         addr_d = loadValue;
      end else if (inc) begin
         addr_d = addr_incr(addr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr = addr_q;

endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: byte-burst sequencer for an asynchronous-style memory with
// active-low read/write strobes.
// Parameter:
//   STROBE_CYCLES : cycles each strobe is held low (1..15)
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   cmdValid/cmdReady          : burst command handshake
//   cmdWrite, cmdAddr, cmdLen  : direction, start address, length-1
//   wrData/wrValid/wrReady     : write-byte stream in
//   rdData/rdValid/rdReady     : read-byte stream out
//   done                       : one-cycle pulse after the burst's last byte
//   readEnable, writeEnable    : active-low memory strobes (registered)
//   memWData, memRData         : memory data out / in
//   addrBank/addrBlock/addrRow : memory address fields
//   verifyErr                  : sticky write-verify error
//                                (only with MEM_SEQUENCER_VERIFY_EN defined)
module mem_sequencer
   import mem_seq_pkg::*;
#(
   parameter int unsigned STROBE_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmdValid,
   output logic               cmdReady,
   input  logic               cmdWrite,
   input  logic [15:0]        cmdAddr,
   input  logic [7:0]         cmdLen,
   input  logic [7:0]         wrData,
   input  logic               wrValid,
   output logic               wrReady,
   output logic [7:0]         rdData,
   output logic               rdValid,
   input  logic               rdReady,
   output logic               done,
`ifdef MEM_SEQUENCER_VERIFY_EN
   output logic               verifyErr,
`endif
   output logic               readEnable,
   output logic               writeEnable,
   output logic [7:0]         memWData,
   input  logic [7:0]         memRData,
   output logic [BANK_W-1:0]  addrBank,
   output logic [BLOCK_W-1:0] addrBlock,
   output logic [ROW_W-1:0]   addrRow
);

   localparam logic [3:0] STB_LAST = 4'(STROBE_CYCLES - 1);

   state_e     state_q, state_d;
   logic       wr_q, wr_d;
   logic [7:0] len_q, len_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic       done_q, done_d;
   logic       cmd_ready_q, cmd_ready_d;
   logic       re_n_q, re_n_d;
   logic       we_n_q, we_n_d;
   logic       byte_end;
   logic       addr_load;
   logic       addr_inc;
   mem_addr_t  addr;
`ifdef MEM_SEQUENCER_VERIFY_EN
   logic       err_q, err_d;
`endif

   mem_addr_counter u_addr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (addr_load),
      .loadValue (mem_addr_t'(cmdAddr)),
      .inc       (addr_inc),
      .addr      (addr)
   );

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      done_d    = 1'b0;
      byte_end  = 1'b0;
      addr_load = 1'b0;
      addr_inc  = 1'b0;
`ifdef MEM_SEQUENCER_VERIFY_EN
      err_d     = err_q;
`endif

      case (state_q)
         IDLE: begin
            if (cmdValid && cmdReady) begin
               wr_d      = cmdWrite;
               len_d     = cmdLen;
               addr_load = 1'b1;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            cnt_d = '0;
            if (wr_q) begin
               if (wrValid) begin
                  wdata_d = wrData;
                  state_d = STROBE;
               end
            end else begin
               state_d = STROBE;
            end
         end
         STROBE: begin
            if (cnt_q == STB_LAST) begin
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HOLD: begin
            if (wr_q) begin
`ifdef MEM_SEQUENCER_VERIFY_EN
               cnt_d   = '0;
               state_d = VSTROBE;
`else
               byte_end = 1'b1;
`endif
            end else begin
               rdata_d = memRData;
               state_d = RDWAIT;
            end
         end
         RDWAIT: begin
            if (rdReady) begin
               byte_end = 1'b1;
            end
         end
`ifdef MEM_SEQUENCER_VERIFY_EN
         VSTROBE: begin
            if (cnt_q == STB_LAST) begin
               state_d = VHOLD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         VHOLD: begin
            if (memRData != wdata_q) begin
               err_d = 1'b1;
            end
            byte_end = 1'b1;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // Shared tail of every completed byte: next byte or end of burst.
      if (byte_end) begin
         if (len_q == 8'd0) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end else begin
            len_d    = len_q - 8'd1;
            addr_inc = 1'b1;
            state_d  = SETUP;
         end
      end

      // Strobes and cmdReady are registered from the next state so they are
      // glitch-free. cmdReady stays low during the done cycle so a command
      // presented alongside done is only taken on the following edge.
      we_n_d      = !((state_d == STROBE) && wr_d);
`ifdef MEM_SEQUENCER_VERIFY_EN
      re_n_d      = !(((state_d == STROBE) && !wr_d) || (state_d == VSTROBE));
`else
      re_n_d      = !((state_d == STROBE) && !wr_d);
`endif
      cmd_ready_d = (state_d == IDLE) && !done_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         len_q       <= '0;
         cnt_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
         re_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         cmd_ready_q <= cmd_ready_d;
         re_n_q      <= re_n_d;
         we_n_q      <= we_n_d;
      end
   end

`ifdef MEM_SEQUENCER_VERIFY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign verifyErr = err_q;
`endif

   assign cmdReady    = cmd_ready_q;
   assign wrReady     = (state_q == SETUP) && wr_q;
   assign rdValid     = (state_q == RDWAIT);
   assign rdData      = rdata_q;
   assign done        = done_q;
   assign readEnable  = re_n_q;
   assign writeEnable = we_n_q;
   assign memWData    = wdata_q;
   assign addrBank    = addr.bank;
   assign addrBlock   = addr.block;
   assign addrRow     = addr.row;

endmodule

// File: tb/tb_mem_sequencer.sv
// Testbench for mem_sequencer (STROBE_CYCLES = 1) with a 64 KiB memory model.
module tb_mem_sequencer;

   logic        clk;
   logic        rst_n;
   logic        cmdValid, cmdReady, cmdWrite;
   logic [15:0] cmdAddr;
   logic [7:0]  cmdLen;
   logic [7:0]  wrData;
   logic        wrValid, wrReady;
   logic [7:0]  rdData;
   logic        rdValid, rdReady;
   logic        done;
   logic        readEnable, writeEnable;
   logic [7:0]  memWData, memRData;
   logic [3:0]  addrBank, addrBlock;
   logic [7:0]  addrRow;
`ifdef MEM_SEQUENCER_VERIFY_EN
   logic        verifyErr;
`endif

   mem_sequencer #(.STROBE_CYCLES(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmdValid    (cmdValid),
      .cmdReady    (cmdReady),
      .cmdWrite    (cmdWrite),
      .cmdAddr     (cmdAddr),
      .cmdLen      (cmdLen),
      .wrData      (wrData),
      .wrValid     (wrValid),
      .wrReady     (wrReady),
      .rdData      (rdData),
      .rdValid     (rdValid),
      .rdReady     (rdReady),
      .done        (done),
`ifdef MEM_SEQUENCER_VERIFY_EN
      .verifyErr   (verifyErr),
`endif
      .readEnable  (readEnable),
      .writeEnable (writeEnable),
      .memWData    (memWData),
      .memRData    (memRData),
      .addrBank    (addrBank),
      .addrBlock   (addrBlock),
      .addrRow     (addrRow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory model: combinational read, write on clock edge while writeEnable low.
   logic [7:0]  mem [0:65535];
   logic [15:0] maddr;
   logic [15:0] flip_addr = 16'h0000;
   logic        flip_en   = 1'b0;
   assign maddr    = {addrBank, addrBlock, addrRow};
   assign memRData = mem[maddr] ^ {7'd0, (flip_en && (maddr == flip_addr))};
   always @(posedge clk) if (writeEnable === 1'b0) mem[maddr] <= memWData;

   // Monitors.
   typedef struct { logic [15:0] a; logic [7:0] d; } wrec_t;
   wrec_t wlog[$];
   int    done_cnt   = 0;
   int    accepts    = 0;
   int    rd_strobes = 0;
   bit    mon_en     = 1'b0;
   logic  we_prev    = 1'b1;
   logic  re_prev    = 1'b1;

   always @(negedge clk) begin
      if (mon_en) chk("strobe_overlap", {31'd0, readEnable | writeEnable}, 1);
      if (done === 1'b1) done_cnt++;
      if (writeEnable === 1'b0 && we_prev === 1'b1) wlog.push_back('{maddr, memWData});
      if (readEnable === 1'b0 && re_prev === 1'b1) rd_strobes++;
      we_prev = writeEnable;
      re_prev = readEnable;
   end

   always @(posedge clk) if (rst_n && cmdValid && cmdReady) accepts++;

   function automatic logic [7:0] byte_of(input logic [7:0] seed, input int i);
      return seed + 8'((i + 1) * 17);
   endfunction

   task automatic wait_cmd_ready();
      int n = 0;
      @(negedge clk);
      while (cmdReady !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_wait", {31'd0, cmdReady}, 1);
   endtask

   int verr_first;

   // Write burst with wrValid always high; optional cmdValid pokes mid-burst
   // and in the done cycle. cyc = cycles from first SETUP to done.
   task automatic run_write(input logic [15:0] a, input logic [7:0] len,
                            input logic [7:0] seed, input bit poke, output int cyc);
      int  idx = 0;
      bit  xfer;
      wait_cmd_ready();
      cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = a; cmdLen = len;
      wrValid  = 1'b1; wrData = byte_of(seed, 0);
      @(posedge clk); #1;
      cmdValid = 1'b0; cmdAddr = ~a; cmdLen = 8'hFF;
      cyc = -1;
      verr_first = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
`ifdef MEM_SEQUENCER_VERIFY_EN
         if (verifyErr === 1'b1 && verr_first < 0) verr_first = c;
`endif
         if (done === 1'b1) begin
            cyc = c;
            chk("done_cycle_cmdready", {31'd0, cmdReady}, 0);
            cmdValid = poke;
            @(posedge clk); #1;
            break;
         end
         cmdValid = poke & c[0];
         xfer = wrReady;
         @(posedge clk); #1;
         if (xfer) begin
            idx++;
            wrData = byte_of(seed, idx);
         end
      end
      cmdValid = 1'b0;
      wrValid  = 1'b0;
      if (cyc < 0) chk("write_timeout", 1, 0);
   endtask

   // Read burst; rdReady held low for stall_n cycles on byte stall_idx.
   task automatic run_read(input logic [15:0] a, input logic [7:0] len, input logic [7:0] seed,
                           input int stall_idx, input int stall_n, output int cyc);
      int idx = 0;
      int stalled = 0;
      bit stalling = 1'b0;
      wait_cmd_ready();
      cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = a; cmdLen = len; rdReady = 1'b1;
      @(posedge clk); #1;
      cmdValid = 1'b0; cmdAddr = ~a;
      cyc = -1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            cyc = c;
            break;
         end
         cmdValid = c[0];
         if (stalling) chk("stall_hold", {23'd0, rdValid, rdData}, {23'd0, 1'b1, byte_of(seed, idx)});
         if (rdValid === 1'b1) begin
            if (idx == stall_idx && stalled < stall_n) begin
               stalled++;
               stalling = 1'b1;
               rdReady  = 1'b0;
            end else begin
               chk("rd_data", {24'd0, rdData}, {24'd0, byte_of(seed, idx)});
               idx++;
               stalling = 1'b0;
               rdReady  = 1'b1;
            end
         end else begin
            rdReady = 1'b1;
         end
      end
      cmdValid = 1'b0;
      rdReady  = 1'b1;
      chk("rd_byte_count", idx, 32'(len) + 1);
      if (cyc < 0) chk("read_timeout", 1, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_strobes"}, {30'd0, readEnable, writeEnable}, 3);
      chk({tag, "_hs"}, {28'd0, cmdReady, wrReady, rdValid, done}, 0);
      chk({tag, "_addr"}, {16'd0, maddr}, 0);
      chk({tag, "_data"}, {16'd0, rdData, memWData}, 0);
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  len;
      logic [7:0]  seed;
      logic [15:0] exp_last;
      int          exp_cyc;
   } wvec_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  len;
      logic [7:0]  seed;
      int          stall_idx;
      int          stall_n;
      int          exp_cyc;
   } rvec_t;

   wvec_t wv[5];
   rvec_t rv[3];

   initial begin
      int cyc, acc0, dn0, rs0, wexp;

      wv[0] = '{16'h3A10, 8'd2, 8'h00, 16'h3A12, 9};
      wv[1] = '{16'h0FFF, 8'd1, 8'h40, 16'h1000, 6};
      wv[2] = '{16'hFFFF, 8'd1, 8'h80, 16'h0000, 6};
      wv[3] = '{16'h12FF, 8'd0, 8'h5A, 16'h12FF, 3};
      wv[4] = '{16'h00FE, 8'd3, 8'hC3, 16'h0101, 12};

      rv[0] = '{16'h3A10, 8'd2, 8'h00, 1, 4, 16};
      rv[1] = '{16'h00FE, 8'd3, 8'hC3, 99, 0, 16};
      rv[2] = '{16'hFFFF, 8'd1, 8'h80, 0, 2, 10};

      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

      rst_n = 1'b0; cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdLen = '0;
      wrData = '0; wrValid = 1'b0; rdReady = 1'b1;

      // Reset state.
      repeat (2) @(posedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("cmdready_after_release", {31'd0, cmdReady}, 1);

      // Write bursts: strobe count, addresses (incl. carries/wrap), data, timing.
      foreach (wv[i]) begin
         acc0 = accepts; dn0 = done_cnt; wlog.delete();
         run_write(wv[i].addr, wv[i].len, wv[i].seed, 1'b1, cyc);
         repeat (2) @(negedge clk);
`ifdef MEM_SEQUENCER_VERIFY_EN
         wexp = wv[i].exp_cyc / 3 * 5;
`else
         wexp = wv[i].exp_cyc;
`endif
         chk("wr_accepts", accepts - acc0, 1);
         chk("wr_done_count", done_cnt - dn0, 1);
         chk("wr_cycles", cyc, wexp);
         chk("wr_strobes", wlog.size(), 32'(wv[i].len) + 1);
         if (wlog.size() > 0) begin
            chk("wr_first_addr", {16'd0, wlog[0].a}, {16'd0, wv[i].addr});
            chk("wr_last_addr", {16'd0, wlog[$].a}, {16'd0, wv[i].exp_last});
         end
         foreach (wlog[k]) chk("wr_data", {24'd0, wlog[k].d}, {24'd0, byte_of(wv[i].seed, k)});
      end

      // Read bursts with stalls.
      foreach (rv[i]) begin
         acc0 = accepts; dn0 = done_cnt; rs0 = rd_strobes;
         run_read(rv[i].addr, rv[i].len, rv[i].seed, rv[i].stall_idx, rv[i].stall_n, cyc);
         repeat (2) @(negedge clk);
         chk("rd_accepts", accepts - acc0, 1);
         chk("rd_done_count", done_cnt - dn0, 1);
         chk("rd_cycles", cyc, rv[i].exp_cyc);
         chk("rd_strobes", rd_strobes - rs0, 32'(rv[i].len) + 1);
      end

`ifdef MEM_SEQUENCER_VERIFY_EN
      chk("verify_clean", {31'd0, verifyErr}, 0);
      flip_addr = 16'h4001;
      flip_en   = 1'b1;
      dn0 = done_cnt;
      run_write(16'h4000, 8'd2, 8'h10, 1'b0, cyc);
      repeat (3) @(negedge clk);
      flip_en = 1'b0;
      chk("verify_rise_cycle", verr_first, 10);
      chk("verify_done_cycle", cyc, 15);
      chk("verify_done_count", done_cnt - dn0, 1);
      chk("verify_sticky", {31'd0, verifyErr}, 1);
`endif

      // Reset during the first strobe of a 4-byte read.
      dn0 = done_cnt;
      wait_cmd_ready();
      cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 16'h2000; cmdLen = 8'd3; rdReady = 1'b1;
      @(posedge clk); #1;
      cmdValid = 1'b0;
      begin
         int n = 0;
         @(negedge clk);
         while (readEnable !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("rst_test_strobe_seen", {31'd0, readEnable}, 0);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("midburst_reset");
`ifdef MEM_SEQUENCER_VERIFY_EN
      chk("verify_cleared", {31'd0, verifyErr}, 0);
`endif
      @(negedge clk);
      chk("cmdready_in_reset", {31'd0, cmdReady}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("cmdready_release", {31'd0, cmdReady}, 1);
      repeat (8) @(negedge clk);
      chk("no_done_after_abort", done_cnt - dn0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 1, number of cycles each active-low strobe stays low (legal range 1..15).
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 cmdValid/cmdReady  in/out  1/1  command handshake; transfer when both are high on a clk edge.
REQ-005 cmdWrite  in  1  1=write burst, 0=read burst.
REQ-006 cmdAddr  in  16  start address: [15:12] bank, [11:8] block, [7:0] row.
REQ-007 cmdLen  in  8  burst length minus one (0 = 1 byte, 255 = 256 bytes).
REQ-008 wrData/wrValid/wrReady  in/in/out  8/1/1  write-byte handshake.
REQ-009 rdData/rdValid/rdReady  out/out/in  8/1/1  read-byte handshake.
REQ-010 done  out  1  one-cycle pulse after the last byte of a burst completes.
REQ-011 readEnable, writeEnable  out  1 each  active-low memory strobes; idle high.
REQ-012 memWData  out  8  byte driven to the memory data input.
REQ-013 memRData  in  8  byte returned by the memory.
REQ-014 addrBank/addrBlock/addrRow  out  4/4/8  memory address fields.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD, RDWAIT, plus VSTROBE and VHOLD when verify is compiled in (see REQ-032).
REQ-016 IDLE: cmdReady=1; a command transfer latches cmdWrite, cmdAddr and cmdLen, then moves to SETUP.
REQ-017 cmdReady SHALL be 0 in every state except IDLE.
REQ-018 SETUP (write): wrReady=1; a wrValid&&wrReady transfer latches wrData into memWData and moves to STROBE; otherwise stays in SETUP.
REQ-019 SETUP (read): lasts exactly one cycle, then moves to STROBE.
REQ-020 Address outputs and memWData SHALL be stable from SETUP through HOLD; both strobes high in SETUP.
REQ-021 STROBE: the selected strobe is low for exactly STROBE_CYCLES cycles, then HOLD; the other strobe stays high.
REQ-022 Both strobes SHALL never be low in the same cycle.
REQ-023 HOLD: both strobes high.
- Write: if bytes remain, advance address and go to SETUP.
- Write: otherwise pulse done and go to IDLE.
- Read: capture memRData into rdData and go to RDWAIT.
REQ-024 RDWAIT: rdValid=1 and rdData held until rdReady=1.
- On that transfer, advance address and go to SETUP if bytes remain.
- Otherwise pulse done and go to IDLE.
REQ-025 Address advance SHALL be a 16-bit increment of {bank,block,row}:
- row 255→0 carries into block;
- block 15→0 carries into bank;
- 0xFFFF wraps to 0x0000 silently.
REQ-026 Minimum per-byte time SHALL be 2+STROBE_CYCLES cycles (write, with wrValid already high) or 3+STROBE_CYCLES cycles (read, with rdReady already high).
REQ-027 A cmdValid arriving while not in IDLE SHALL be ignored; cmdValid in the same cycle as done is not accepted until the next cycle.

Reset
REQ-028 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE and outputs SHALL take these values:
- readEnable=1, writeEnable=1;
- cmdReady=0 during reset, 1 from the first cycle after release;
- wrReady=0, rdValid=0, done=0;
- rdData=0, memWData=0, all address outputs=0.
REQ-029 Reset mid-burst SHALL abort the burst with no done pulse; an in-progress strobe returns high at that edge.

Configuration
REQ-030 Macro MEM_SEQUENCER_VERIFY_EN SHALL enable write-verify.
REQ-031 With the macro defined, the module SHALL add output verifyErr, 1 bit, sticky, cleared only by reset.
REQ-032 With the macro defined, write HOLD SHALL go to VSTROBE: readEnable low for STROBE_CYCLES cycles at the same address.
REQ-033 VHOLD SHALL compare memRData against memWData and set verifyErr on mismatch, then continue as the write HOLD branch of REQ-023.
REQ-034 Without the macro, the verifyErr port, VSTROBE and VHOLD SHALL be absent, and write timing SHALL be as in REQ-026.

Structure
REQ-035 Package mem_seq_pkg SHALL hold:
- the FSM state enum;
- the field widths BANK_W=4, BLOCK_W=4, ROW_W=8;
- a packed address struct {bank, block, row}.
REQ-036 Address increment and wrap SHALL live in sub-module mem_addr_counter (inputs: load, loadValue, inc; output: current address).

Verification
REQ-037 Write cmdAddr=0x3A10, cmdLen=2, bytes 0x11/0x22/0x33, STROBE_CYCLES=1 → three writeEnable low pulses at rows 0x10/0x11/0x12, one done pulse, 9 cycles from first SETUP to done.
REQ-038 Read back cmdAddr=0x3A10, cmdLen=2 with rdReady held low for 4 cycles on byte 2 → rdData 0x11, 0x22, 0x33 delivered in order; byte 2 rdValid stays high through the stall; no extra strobe is issued.
REQ-039 Write 2 bytes at cmdAddr=0x0FFF → second byte at bank 1, block 0, row 0; a 2-byte write at 0xFFFF → second byte at 0x0000.
REQ-040 Assert rst_n=0 during the STROBE of byte 1 of a 4-byte read → both strobes high at the next edge, no done pulse, cmdReady=1 one cycle after release.
REQ-041 With MEM_SEQUENCER_VERIFY_EN, a memory model forcing bit 0 of one read to flip → verifyErr rises in the VHOLD of that byte and stays set until reset; the burst still completes with done.
REQ-042 Check every cycle that readEnable and writeEnable are never low simultaneously, and that cmdValid pulses during a burst are never accepted.
